ball_motion: RTL and testbench

//  Ball engine for Pong: owns ball position/direction, the producer side of the ball/paddle interface.

---
 rtl/pong_pkg.sv | 42 ++++
 rtl/pong_score_counter.sv | 32 +++
 rtl/ball_motion.sv | 211 +++++++++++++++++++++
 tb/tb_ball_motion.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared Pong geometry, game constants and ball state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: screen and paddle geometry, ball speed and serve timing,
// ball_state_t (also decoded by the paddles block), and a paddle overlap helper.
package pong_pkg;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int BALL_SIZE   = 8;
  localparam int SPEED       = 2;
  localparam int PADDLE_W    = 8;
  localparam int PADDLE_H    = 64;
  localparam int PLAYER_X    = 16;
  localparam int AI_X        = 616;
  localparam int SERVE_TICKS = 60;
  localparam int WIN_SCORE   = 7;

  typedef enum logic [1:0] {
    ST_SERVE     = 2'd0,
    ST_PLAY      = 2'd1,
    ST_SCORED    = 2'd2,
    ST_GAME_OVER = 2'd3
  } ball_state_t;

  localparam logic signed [11:0] BALL_S     = 12'(BALL_SIZE);
  localparam logic signed [11:0] HALF_PAD_S = 12'(PADDLE_H / 2);

  // Vertical overlap of the ball square with a paddle given its centre y.
  // Signed so a paddle centred near the top (centre - half height < 0)
  // still compares correctly.
  function automatic logic paddle_overlap(input logic [9:0] ball_y,
                                          input logic [9:0] paddle_y);
    logic signed [11:0] by;
    logic signed [11:0] py;
    by = $signed({2'b00, ball_y});
    py = $signed({2'b00, paddle_y});
    return ((by + BALL_S) > (py - HALF_PAD_S)) && (by < (py + HALF_PAD_S));
  endfunction

endpackage

// File: rtl/pong_score_counter.sv
// Saturating 4-bit score counter with win-flag.
// Latency: score updates the cycle after incr/clear.
// Backpressure: none; incr is ignored once the score has reached WIN.
//
// Ports: clk, reset (sync, active-high), clear (sync zero), incr (add one),
//        score (current count), at_win (score equals WIN).
module pong_score_counter
  import pong_pkg::*;
#(
  parameter int WIN = WIN_SCORE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       incr,
  output logic [3:0] score,
  output logic       at_win
);

  localparam logic [3:0] WIN_VAL = 4'(WIN);

  assign at_win = (score == WIN_VAL);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      score <= 4'd0;
    end else if (incr && !at_win) begin
      score <= score + 4'd1;
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Pong ball engine: position/direction, wall and paddle bounce, scoring, serve and game-over.
// Latency: all outputs registered; motion shows up the cycle after a move_tick.
// Backpressure: none; move_tick is a strobe and state holds between strobes.
//
// Ports: clk, reset (sync, active-high), move_tick (motion strobe), start (leave GAME_OVER),
//        player_paddle_y / ai_paddle_y (paddle centres), ball_pos_x / ball_pos_y (top-left),
//        ball_state, ball_dir_x (1=right), ball_dir_y (1=down), paddle_hit / player_point /
//        ai_point (one-cycle pulses), player_score / ai_score.
module ball_motion
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       move_tick,
  input  logic       start,
  input  logic [9:0] player_paddle_y,
  input  logic [9:0] ai_paddle_y,
  output logic [9:0] ball_pos_x,
  output logic [9:0] ball_pos_y,
  output logic [1:0] ball_state,
  output logic       ball_dir_x,
  output logic       ball_dir_y,
  output logic       paddle_hit,
  output logic       player_point,
  output logic       ai_point,
  output logic [3:0] player_score,
  output logic [3:0] ai_score
);

  localparam int CNT_W = $clog2(SERVE_TICKS);

  localparam logic [9:0]  CENTRE_X   = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  CENTRE_Y   = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_BOTTOM10 = 10'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0]  FACE_L10   = 10'(PLAYER_X + PADDLE_W);
  localparam logic [9:0]  FACE_R10   = 10'(AI_X - BALL_SIZE);
  localparam logic [9:0]  STEP10     = 10'(SPEED);
  localparam logic [10:0] Y_BOTTOM   = 11'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0] FACE_L     = 11'(PLAYER_X + PADDLE_W);
  localparam logic [10:0] FACE_R     = 11'(AI_X);
  localparam logic [10:0] X_LIMIT    = 11'(SCREEN_W);
  localparam logic [10:0] STEP       = 11'(SPEED);
  localparam logic [10:0] BALL       = 11'(BALL_SIZE);
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_TICKS - 1);

  ball_state_t      state, state_nxt;
  logic [CNT_W-1:0] serve_cnt, serve_cnt_nxt;
  logic [9:0]       pos_x_nxt, pos_y_nxt;
  logic             dir_x_nxt, dir_y_nxt;
  logic             hit_nxt, player_point_nxt, ai_point_nxt;
  logic             player_incr, ai_incr, score_clear;
  logic             player_at_win, ai_at_win;

  // 11-bit views so x+size+speed and y+speed never wrap.
  logic [10:0] x_ext, y_ext, x_right;
  logic        player_ovl, ai_ovl;

  assign x_ext      = {1'b0, ball_pos_x};
  assign y_ext      = {1'b0, ball_pos_y};
  assign x_right    = x_ext + BALL;
  // Overlap is judged on the pre-move y, so the hit decision is independent
  // of the wall bounce taken on the same tick.
  assign player_ovl = paddle_overlap(ball_pos_y, player_paddle_y);
  assign ai_ovl     = paddle_overlap(ball_pos_y, ai_paddle_y);

  assign ball_state = state;

  always_comb begin
    state_nxt        = state;
    serve_cnt_nxt    = serve_cnt;
    pos_x_nxt        = ball_pos_x;
    pos_y_nxt        = ball_pos_y;
    dir_x_nxt        = ball_dir_x;
    dir_y_nxt        = ball_dir_y;
    hit_nxt          = 1'b0;
    player_point_nxt = 1'b0;
    ai_point_nxt     = 1'b0;
    player_incr      = 1'b0;
    ai_incr          = 1'b0;
    score_clear      = 1'b0;

    unique case (state)
      ST_SERVE: begin
        if (move_tick) begin
          if (serve_cnt == SERVE_LAST) begin
            state_nxt     = ST_PLAY;
            serve_cnt_nxt = '0;
          end else begin
            serve_cnt_nxt = serve_cnt + CNT_W'(1);
          end
        end
      end

      ST_PLAY: begin
        if (move_tick) begin
          // Vertical: clamp to the wall and reflect.
          if (ball_dir_y) begin
            if (y_ext + STEP >= Y_BOTTOM) begin
              pos_y_nxt = Y_BOTTOM10;
              dir_y_nxt = 1'b0;
            end else begin
              pos_y_nxt = ball_pos_y + STEP10;
            end
          end else if (y_ext <= STEP) begin
            pos_y_nxt = '0;
            dir_y_nxt = 1'b1;
          end else begin
            pos_y_nxt = ball_pos_y - STEP10;
          end

          // Horizontal: a deflection only happens when this step would cross
          // the paddle face; once past the face the ball runs to the edge.
          if (!ball_dir_x) begin
            if (x_ext > FACE_L && x_ext - STEP <= FACE_L && player_ovl) begin
              pos_x_nxt = FACE_L10;
              dir_x_nxt = 1'b1;
              hit_nxt   = 1'b1;
            end else if (x_ext < STEP) begin
              ai_point_nxt = 1'b1;
              ai_incr      = 1'b1;
              state_nxt    = ST_SCORED;
            end else begin
              pos_x_nxt = ball_pos_x - STEP10;
            end
          end else begin
            if (x_right < FACE_R && x_right + STEP >= FACE_R && ai_ovl) begin
              pos_x_nxt = FACE_R10;
              dir_x_nxt = 1'b0;
              hit_nxt   = 1'b1;
            end else if (x_right + STEP > X_LIMIT) begin
              player_point_nxt = 1'b1;
              player_incr      = 1'b1;
              state_nxt        = ST_SCORED;
            end else begin
              pos_x_nxt = ball_pos_x + STEP10;
            end
          end
        end
      end

      ST_SCORED: begin
        // Scores already carry the new point here. dir_x is left alone: the
        // ball was travelling toward the side that conceded, which is where
        // the next serve goes.
        pos_x_nxt = CENTRE_X;
        pos_y_nxt = CENTRE_Y;
        if (player_at_win || ai_at_win) begin
          state_nxt = ST_GAME_OVER;
        end else begin
          state_nxt     = ST_SERVE;
          serve_cnt_nxt = '0;
        end
      end

      ST_GAME_OVER: begin
        pos_x_nxt = CENTRE_X;
        pos_y_nxt = CENTRE_Y;
        if (start) begin
          score_clear   = 1'b1;
          serve_cnt_nxt = '0;
          state_nxt     = ST_SERVE;
        end
      end

      default: state_nxt = ST_SERVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_SERVE;
      serve_cnt    <= '0;
      ball_pos_x   <= CENTRE_X;
      ball_pos_y   <= CENTRE_Y;
      ball_dir_x   <= 1'b1;
      ball_dir_y   <= 1'b1;
      paddle_hit   <= 1'b0;
      player_point <= 1'b0;
      ai_point     <= 1'b0;
    end else begin
      state        <= state_nxt;
      serve_cnt    <= serve_cnt_nxt;
      ball_pos_x   <= pos_x_nxt;
      ball_pos_y   <= pos_y_nxt;
      ball_dir_x   <= dir_x_nxt;
      ball_dir_y   <= dir_y_nxt;
      paddle_hit   <= hit_nxt;
      player_point <= player_point_nxt;
      ai_point     <= ai_point_nxt;
    end
  end

  pong_score_counter #(.WIN(WIN_SCORE)) u_player_score (
    .clk    (clk),
    .reset  (reset),
    .clear  (score_clear),
    .incr   (player_incr),
    .score  (player_score),
    .at_win (player_at_win)
  );

  pong_score_counter #(.WIN(WIN_SCORE)) u_ai_score (
    .clk    (clk),
    .reset  (reset),
    .clear  (score_clear),
    .incr   (ai_incr),
    .score  (ai_score),
    .at_win (ai_at_win)
  );

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: integer game model compared every cycle,
// plus hand-computed literal expectations along one long directed rally.
// Ports of the DUT are all driven/observed here.
module tb_ball_motion;

  localparam int CX       = 316;
  localparam int CY       = 236;
  localparam int Y_BOT    = 472;
  localparam int FACE_L   = 24;
  localparam int FACE_R   = 616;
  localparam int SCR_W    = 640;
  localparam int BSZ      = 8;
  localparam int STEP     = 2;
  localparam int HALF_PAD = 32;
  localparam int SERVE_N  = 60;
  localparam int WIN      = 7;

  logic       clk = 1'b0;
  logic       reset, move_tick, start;
  logic [9:0] player_paddle_y, ai_paddle_y;
  logic [9:0] ball_pos_x, ball_pos_y;
  logic [1:0] ball_state;
  logic       ball_dir_x, ball_dir_y, paddle_hit, player_point, ai_point;
  logic [3:0] player_score, ai_score;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Model state: 0 serve, 1 play, 2 scored, 3 game over.
  int m_x, m_y, m_dx, m_dy, m_state, m_cnt, m_ps, m_as;
  int m_hit, m_pp, m_ap, m_left_conceded;
  int nx, ny, ndx, ndy;

  ball_motion dut (
    .clk             (clk),
    .reset           (reset),
    .move_tick       (move_tick),
    .start           (start),
    .player_paddle_y (player_paddle_y),
    .ai_paddle_y     (ai_paddle_y),
    .ball_pos_x      (ball_pos_x),
    .ball_pos_y      (ball_pos_y),
    .ball_state      (ball_state),
    .ball_dir_x      (ball_dir_x),
    .ball_dir_y      (ball_dir_y),
    .paddle_hit      (paddle_hit),
    .player_point    (player_point),
    .ai_point        (ai_point),
    .player_score    (player_score),
    .ai_score        (ai_score)
  );

  always #5 clk = ~clk;

  function automatic bit overlaps(input int y, input int p);
    return (y + BSZ > p - HALF_PAD) && (y < p + HALF_PAD);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input int exp);
    n_checks++;
    if (act !== 16'(exp)) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: rules of the game, integer arithmetic.
  always @(posedge clk) begin
    if (reset) begin
      m_x = CX; m_y = CY; m_dx = 1; m_dy = 1; m_state = 0; m_cnt = 0;
      m_ps = 0; m_as = 0; m_hit = 0; m_pp = 0; m_ap = 0; m_left_conceded = 0;
    end else begin
      m_hit = 0; m_pp = 0; m_ap = 0;
      case (m_state)
        0: if (move_tick) begin
          if (m_cnt == SERVE_N - 1) begin m_state = 1; m_cnt = 0; end
          else m_cnt = m_cnt + 1;
        end
        1: if (move_tick) begin
          ny = m_y; ndy = m_dy; nx = m_x; ndx = m_dx;
          if (m_dy == 1) begin
            if (m_y + STEP >= Y_BOT) begin ny = Y_BOT; ndy = 0; end
            else ny = m_y + STEP;
          end else begin
            if (m_y <= STEP) begin ny = 0; ndy = 1; end
            else ny = m_y - STEP;
          end
          if (m_dx == 0) begin
            if (m_x > FACE_L && m_x - STEP <= FACE_L && overlaps(m_y, int'(player_paddle_y))) begin
              nx = FACE_L; ndx = 1; m_hit = 1;
            end else if (m_x < STEP) begin
              m_ap = 1; if (m_as < WIN) m_as = m_as + 1; m_state = 2; m_left_conceded = 1;
            end else nx = m_x - STEP;
          end else begin
            if (m_x + BSZ < FACE_R && m_x + BSZ + STEP >= FACE_R && overlaps(m_y, int'(ai_paddle_y))) begin
              nx = FACE_R - BSZ; ndx = 0; m_hit = 1;
            end else if (m_x + BSZ + STEP > SCR_W) begin
              m_pp = 1; if (m_ps < WIN) m_ps = m_ps + 1; m_state = 2; m_left_conceded = 0;
            end else nx = m_x + STEP;
          end
          m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
        end
        2: begin
          m_x = CX; m_y = CY;
          if (m_as == WIN || m_ps == WIN) m_state = 3;
          else begin
            m_state = 0; m_cnt = 0;
            m_dx = m_left_conceded ? 0 : 1;
          end
        end
        default: begin
          m_x = CX; m_y = CY;
          if (start) begin m_ps = 0; m_as = 0; m_cnt = 0; m_state = 0; end
        end
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ball_pos_x", ball_pos_x, m_x);
      chk("ball_pos_y", ball_pos_y, m_y);
      chk("ball_state", ball_state, m_state);
      chk("ball_dir_x", ball_dir_x, m_dx);
      chk("ball_dir_y", ball_dir_y, m_dy);
      chk("paddle_hit", paddle_hit, m_hit);
      chk("player_point", player_point, m_pp);
      chk("ai_point", ai_point, m_ap);
      chk("player_score", player_score, m_ps);
      chk("ai_score", ai_score, m_as);
    end
  end

  task automatic tick1();
    move_tick = 1'b1;
    @(posedge clk); #1;
    move_tick = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick1();
      idle();
    end
  endtask

  initial begin
    reset = 1'b1; move_tick = 1'b0; start = 1'b0;
    player_paddle_y = 10'd170; ai_paddle_y = 10'd420;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("rst_x", ball_pos_x, 316);
    chk("rst_y", ball_pos_y, 236);
    chk("rst_state", ball_state, 0);
    chk("rst_dirs", {ball_dir_x, ball_dir_y}, 3);
    chk("rst_scores", {player_score, ai_score}, 0);
    reset = 1'b0;

    // Serve delay then first PLAY step.
    tick_n(59);
    chk("serve59_state", ball_state, 0);
    chk("serve59_x", ball_pos_x, 316);
    tick_n(1);
    chk("serve60_state", ball_state, 1);
    tick_n(1);
    chk("play1_x", ball_pos_x, 318);
    chk("play1_y", ball_pos_y, 238);

    // Bottom wall.
    tick_n(116);
    chk("pre_bot_y", ball_pos_y, 470);
    tick_n(1);
    chk("bot_y", ball_pos_y, 472);
    chk("bot_dir_y", ball_dir_y, 0);
    chk("bot_x", ball_pos_x, 552);

    // AI paddle deflection (paddle centre 420, ball y 418).
    tick_n(27);
    chk("pre_ai_x", ball_pos_x, 606);
    tick1();
    chk("ai_hit_pulse", paddle_hit, 1);
    chk("ai_hit_x", ball_pos_x, 608);
    chk("ai_hit_dir_x", ball_dir_x, 0);
    chk("ai_hit_y", ball_pos_y, 416);
    idle();
    chk("ai_hit_pulse_end", paddle_hit, 0);
    ai_paddle_y = 10'd200;

    // Top wall.
    tick_n(207);
    chk("pre_top_y", ball_pos_y, 2);
    tick_n(1);
    chk("top_y", ball_pos_y, 0);
    chk("top_dir_y", ball_dir_y, 1);
    chk("top_x", ball_pos_x, 192);

    // Player paddle deflection (centre 170, ball y 166).
    tick_n(83);
    chk("pre_pl_x", ball_pos_x, 26);
    chk("pre_pl_y", ball_pos_y, 166);
    tick1();
    chk("pl_hit_pulse", paddle_hit, 1);
    chk("pl_hit_x", ball_pos_x, 24);
    chk("pl_hit_dir_x", ball_dir_x, 1);
    chk("pl_hit_y", ball_pos_y, 168);
    idle();
    player_paddle_y = 10'd1000;

    // Second AI deflection, then the player misses.
    tick_n(291);
    chk("pre_ai2_x", ball_pos_x, 606);
    chk("pre_ai2_y", ball_pos_y, 194);
    tick_n(1);
    chk("ai2_x", ball_pos_x, 608);
    chk("ai2_dir_x", ball_dir_x, 0);
    tick_n(304);
    chk("pre_miss_x", ball_pos_x, 0);
    tick1();
    chk("ai_point_pulse", ai_point, 1);
    chk("ai_score_1", ai_score, 1);
    chk("scored_state", ball_state, 2);
    idle();
    chk("reserve_state", ball_state, 0);
    chk("reserve_x", ball_pos_x, 316);
    chk("reserve_y", ball_pos_y, 236);
    chk("reserve_dir_x", ball_dir_x, 0);
    chk("ai_point_end", ai_point, 0);

    // Six more unanswered AI points: 60 serve ticks + 159 play ticks each.
    for (int p = 0; p < 6; p++) tick_n(219);
    chk("win_ai_score", ai_score, 7);
    chk("win_state", ball_state, 3);
    chk("win_x", ball_pos_x, 316);
    tick_n(5);
    chk("over_state", ball_state, 3);
    chk("over_ai_score", ai_score, 7);
    chk("over_y", ball_pos_y, 236);

    start = 1'b1; idle(); start = 1'b0;
    chk("start_state", ball_state, 0);
    chk("start_ai_score", ai_score, 0);
    start = 1'b1; idle(); start = 1'b0;
    chk("start_in_serve", ball_state, 0);

    // Reset while playing with a tick present.
    tick_n(63);
    chk("replay_state", ball_state, 1);
    reset = 1'b1; move_tick = 1'b1;
    idle();
    reset = 1'b0; move_tick = 1'b0;
    chk("mid_rst_x", ball_pos_x, 316);
    chk("mid_rst_y", ball_pos_y, 236);
    chk("mid_rst_state", ball_state, 0);
    chk("mid_rst_dirs", {ball_dir_x, ball_dir_y}, 3);
    chk("mid_rst_pulses", {paddle_hit, player_point, ai_point}, 0);

    // AI misses: player point after 60 + 159 ticks.
    ai_paddle_y = 10'd1000;
    tick_n(218);
    tick1();
    chk("pl_point_pulse", player_point, 1);
    chk("pl_score_1", player_score, 1);
    chk("pl_scored_x", ball_pos_x, 632);
    idle();
    chk("pl_reserve_state", ball_state, 0);
    chk("pl_reserve_dir_x", ball_dir_x, 1);
    chk("pl_point_end", player_point, 0);

    repeat (3) idle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
